// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter and its prescaler.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // A counter for PRESCALE phases needs $clog2(PRESCALE) bits, but never fewer than one.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE: step is high on the last enabled phase of each interval.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LastPhase = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q, phase_d;

  assign step = en && (phase_q == LastPhase);

  always_comb begin
    phase_d = phase_q;
    if (clr || step) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// General-purpose up/down event counter with programmable limit, wrap/saturate mode,
// prescaled enable, terminal-count pulse and sticky overflow flag.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      PRESCALE  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ud,
  input  logic             mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  // A load also restarts the prescale interval.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr | load),
    .step  (step)
  );

  // Value a step would produce; the boundary test stops natural WIDTH-bit rollover.
  always_comb begin
    boundary = 1'b0;
    stepped  = count_q;
    if (ud == DIR_UP) begin
      if (count_q >= limit) begin
        boundary = 1'b1;
        stepped  = (mode == MODE_WRAP) ? '0 : limit;
      end else begin
        stepped = count_q + WIDTH'(1);
      end
    end else begin
      if (count_q == '0) begin
        boundary = 1'b1;
        stepped  = (mode == MODE_WRAP) ? limit : '0;
      end else begin
        stepped = count_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = RESET_VAL;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
    end else if (step) begin
      count_d = stepped;
      tc_d    = boundary;
      ovf_d   = ovf_q | boundary;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: two instances (PRESCALE 1 and 3) sharing stimulus,
// checked against an arithmetic model of the counting rules.
module tb_updown_counter_param;

  logic clk = 1'b0;
  logic rst_n, en, ud, mode, clr, load;
  logic [3:0] load_val, limit;
  logic [3:0] count1, count3;
  logic tc1, tc3, ovf1, ovf3;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt[2];
  int m_ph[2];
  bit m_tc[2];
  bit m_ovf[2];
  int presc[2] = '{1, 3};

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .PRESCALE(1), .RESET_VAL(4'd0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .mode(mode), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .count(count1), .tc(tc1), .ovf(ovf1)
  );

  updown_counter_param #(.WIDTH(4), .PRESCALE(3), .RESET_VAL(4'd0)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .mode(mode), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .count(count3), .tc(tc3), .ovf(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic apply_step(input int i);
    int lim = int'(limit);
    bit b = 0;
    if (ud == 1'b0) begin
      if (m_cnt[i] < lim) m_cnt[i]++;
      else begin b = 1; m_cnt[i] = mode ? lim : 0; end
    end else begin
      if (m_cnt[i] > 0) m_cnt[i]--;
      else begin b = 1; m_cnt[i] = mode ? 0 : lim; end
    end
    m_tc[i] = b;
    if (b) m_ovf[i] = 1;
  endtask

  task automatic model_update();
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_tc[i] = 0; m_ph[i] = 0;
      end else if (load) begin
        m_cnt[i] = (load_val > limit) ? int'(limit) : int'(load_val);
        m_ph[i] = 0; m_tc[i] = 0;
      end else if (en) begin
        if (m_ph[i] == presc[i] - 1) begin
          m_ph[i] = 0;
          apply_step(i);
        end else begin
          m_ph[i]++;
          m_tc[i] = 0;
        end
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count(p1)"}, 32'(count1), m_cnt[0]);
    chk({tag, " tc(p1)"},    32'(tc1),    32'(m_tc[0]));
    chk({tag, " ovf(p1)"},   32'(ovf1),   32'(m_ovf[0]));
    chk({tag, " count(p3)"}, 32'(count3), m_cnt[1]);
    chk({tag, " tc(p3)"},    32'(tc3),    32'(m_tc[1]));
    chk({tag, " ovf(p3)"},   32'(ovf3),   32'(m_ovf[1]));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ud = 1'b0; mode = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = 4'd0; limit = 4'd9;
    model_reset();
    #3;
    check_all("reset");
    chk("reset count", 32'(count1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap 0..9 then 0, tc only on the wrap.
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle("wrap");
      chk("wrap count", 32'(count1), i % 10);
      chk("wrap tc", 32'(tc1), (i == 10) ? 1 : 0);
    end
    chk("wrap ovf", 32'(ovf1), 1);

    // Saturating down count from a load of 2.
    limit = 4'd15; mode = 1'b1; ud = 1'b1; load_val = 4'd2; load = 1'b1;
    cycle("sat load");
    load = 1'b0;
    chk("sat load count", 32'(count1), 2);
    for (int k = 1; k <= 4; k++) begin
      cycle("sat down");
      chk("sat count", 32'(count1), (k >= 2) ? 0 : 1);
      chk("sat tc", 32'(tc1), (k >= 3) ? 1 : 0);
    end

    // Prescale by 3 with an enable gap mid-interval.
    clr = 1'b1;
    cycle("clr");
    clr = 1'b0; mode = 1'b0; ud = 1'b0; limit = 4'd15; en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle("presc");
      chk("presc count", 32'(count3), i / 3);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("presc hold");
      chk("presc hold count", 32'(count3), 2);
    end
    en = 1'b1;
    cycle("presc resume");
    chk("presc resume count a", 32'(count3), 2);
    cycle("presc resume");
    chk("presc resume count b", 32'(count3), 3);

    // Load beats step and is clamped to limit.
    limit = 4'd9; load_val = 4'd12; load = 1'b1;
    cycle("load clamp");
    load = 1'b0;
    chk("load clamp count", 32'(count1), 9);
    chk("load clamp tc", 32'(tc1), 0);
    cycle("boundary");
    chk("boundary tc", 32'(tc1), 1);
    chk("ovf set before clr", 32'(ovf1), 1);

    // Clear beats load and drops ovf.
    clr = 1'b1; load = 1'b1; load_val = 4'd5;
    cycle("clr+load");
    clr = 1'b0; load = 1'b0;
    chk("clr+load count", 32'(count1), 0);
    chk("clr+load ovf", 32'(ovf1), 0);
    cycle("after clr");

    // Asynchronous reset between clock edges.
    en = 1'b0; limit = 4'd15; load_val = 4'd7; load = 1'b1;
    cycle("preload 7");
    load = 1'b0;
    chk("preload count", 32'(count1), 7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async count", 32'(count1), 0);
    chk("async tc", 32'(tc1), 0);
    chk("async ovf", 32'(ovf1), 0);
    check_all("async");
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; ud = 1'b0; mode = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle("post reset");
      chk("post reset count(p3)", 32'(count3), (i == 3) ? 1 : 0);
    end

    // Randomized traffic, including limit changes below the count and limit = 0.
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(0, 24) == 0);
      load = ($urandom_range(0, 11) == 0);
      en = ($urandom_range(0, 3) != 0);
      load_val = 4'($urandom_range(0, 15));
      if (n % 8 == 0) begin
        ud = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
      end
      if (n % 20 == 0) begin
        case ($urandom_range(0, 3))
          0: limit = 4'd0;
          1: limit = 4'd15;
          default: limit = 4'($urandom_range(1, 14));
        endcase
      end
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
